cx_deserializer: RTL and testbench
==================================

# cx_deserializer

Serial-to-parallel framing stage sitting directly upstream of the combinational (12,7) `decoder`. It assembles received channel bits into 12-bit codewords, buffers completed codewords in a small FIFO and presents them on `cx_out` with a valid/ready handshake, so `cx_out` wires straight to the decoder's `cx` input. It also flags framing slips and buffer overruns for the link monitor.

## Interface
- `CW_W`, 12: codeword width; must match decoder `cx` width.
- `FIFO_DEPTH`, 2: completed-codeword buffer entries (power of two, ≥2).
- `CNT_W`, 8: width of the saturating drop counter.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `sin` in 1: serial channel bit.
- `sin_valid` in 1: `sin` carries a bit this cycle.
- `frame_start` in 1: qualified by `sin_valid`; this bit is codeword bit 0.
- `cx_out` out `CW_W`: head-of-FIFO codeword, feeds decoder `cx`.
- `cx_valid` out 1: `cx_out` holds a codeword.
- `cx_ready` in 1: consumer takes the word when `cx_valid && cx_ready`.
- `overrun` out 1: one-cycle pulse; a completed word was dropped.
- `sync_err` out 1: one-cycle pulse; `frame_start` arrived mid-word.
- `drop_cnt` out `CNT_W`: saturating count of dropped words.
- `inj_en` in 1, `inj_pos` in 4: error-injection controls (only with `CX_ERR_INJECT_EN`).

## Operation
- Two-state FSM: HUNT (reset state) and ASSEMBLE.
- HUNT: bits are ignored until `sin_valid && frame_start`. That bit is stored as bit 0, `bit_cnt` is set to 1, and the FSM goes to ASSEMBLE.
- ASSEMBLE: each `sin_valid` bit is written to index `bit_cnt` (LSB first), then `bit_cnt` increments.
- On the bit with `bit_cnt==CW_W-1`, the word completes:
  - It is pushed to the FIFO and `bit_cnt` wraps to 0.
  - The FSM stays in ASSEMBLE, so the next bit is bit 0 without needing `frame_start`.
- `frame_start` seen in ASSEMBLE with `bit_cnt!=0`:
  - The partial word is discarded and `sync_err` pulses.
  - The current bit becomes bit 0 and `bit_cnt` is set to 1.
- `frame_start` with `bit_cnt==0` is legal and silent.
- Word completes while the FIFO is full and no pop occurs in the same cycle:
  - The word is dropped and `overrun` pulses.
  - `drop_cnt` increments and saturates at all-ones.
- Completion and pop in the same cycle with the FIFO full: the push is accepted and there is no overrun.
- FIFO is first-in first-out. `cx_out` is don't-care but stable while `cx_valid` is low.
- Once `cx_valid` is high, `cx_out` and `cx_valid` hold until a handshake occurs.
- Reset mid-word or with a non-empty FIFO discards everything and returns to HUNT.

## Timing
- Reset values: `cx_out`=0, `cx_valid`=0, `overrun`=0, `sync_err`=0, `drop_cnt`=0, `bit_cnt`=0, FSM=HUNT, FIFO empty.
- Latency: last bit accepted in cycle N gives `cx_valid` high in N+1 when the FIFO was empty.
- A popped slot frees in the pop cycle; with ≥2 buffered words, the next word is on `cx_out` in N+1 after the handshake.
- `overrun` and `sync_err` are registered and assert in the cycle after the causing bit.
- Sustained throughput: one codeword per 12 `sin_valid` cycles. No back-pressure reaches the serial side.

## Configuration
- `CX_ERR_INJECT_EN` defined:
  - `inj_en` and `inj_pos` ports exist and are sampled on the completion cycle.
  - If `inj_en` is high and `inj_pos<CW_W`, bit `inj_pos` of the pushed word is inverted.
  - `inj_pos≥CW_W` injects nothing.
- `CX_ERR_INJECT_EN` undefined: the ports are absent and words pass unmodified.

## Structure
- Package `cw_pkg` holds:
  - `CW_W=12` and `DATA_W=7`;
  - typedef `codeword_t` (`logic [CW_W-1:0]`);
  - FSM enum `cx_state_t {HUNT, ASSEMBLE}`.
- Sub-module `cw_fifo` is a parameterised synchronous FIFO with push/pop/full/empty, holding `codeword_t` entries.
- The top level contains the shifter, `bit_cnt`, the FSM, flags and injection logic.

## Test plan
- **Basic word:** reset, then `frame_start` with 12'hA5C sent LSB first (0,0,1,1,1,0,1,0,0,1,0,1) with `cx_ready`=1 → `cx_out`=12'hA5C and `cx_valid` high exactly one cycle, in the cycle after the 12th bit.
- **Ignored before sync:** 5 bits before any `frame_start` → ignored; the first word is aligned to `frame_start`.
- **Overrun:** `cx_ready`=0, three words 12'h001, 12'h002, 12'h003 → FIFO holds 001, 002; `overrun` pulses once; `drop_cnt`=1. Raising `cx_ready` then pops 001 then 002.
- **Framing slip:** `frame_start` after 7 bits → `sync_err` pulse; the following 12 bits form the next word, and no partial word is emitted.
- **Simultaneous push/pop:** FIFO full and word completes in the same cycle as a pop → no `overrun`; order is preserved.
- **Injection (`CX_ERR_INJECT_EN`):** word 12'h000 with `inj_en`=1, `inj_pos`=5 → `cx_out`=12'h020. With `inj_pos`=13 → 12'h000.

Source files
------------

// File: rtl/cw_pkg.sv
// Shared codeword types and framing FSM encoding for the cx_deserializer slice.
package cw_pkg;
  localparam int CW_W   = 12;
  localparam int DATA_W = 7;

  typedef logic [CW_W-1:0] codeword_t;

  typedef enum logic {
    HUNT,
    ASSEMBLE
  } cx_state_t;
endpackage

// File: rtl/cw_fifo.sv
// Synchronous FIFO for completed codewords; DEPTH must be a power of two.
module cw_fifo
  import cw_pkg::*;
#(
  parameter int W     = CW_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cx_deserializer.sv
// Serial-to-parallel codeword framer feeding the (12,7) decoder.
// Optional bit-error injection on pushed words when CX_ERR_INJECT_EN is defined.
module cx_deserializer
  import cw_pkg::*;
#(
  parameter int CW_W       = cw_pkg::CW_W,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [CW_W-1:0]  cx_out,
  output logic             cx_valid,
  input  logic             cx_ready,
  output logic             overrun,
  output logic             sync_err,
`ifdef CX_ERR_INJECT_EN
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             inj_en,
  input  logic [3:0]       inj_pos
`else
  output logic [CNT_W-1:0] drop_cnt
`endif
);
  localparam int BW = $clog2(CW_W);

  cx_state_t       state;
  cx_state_t       state_nxt;
  logic [BW-1:0]   bit_cnt;
  logic [CW_W-2:0] shreg;
  logic [CW_W-1:0] word;
  logic            capture;
  logic            restart;
  logic            slip;
  logic            complete;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == HUNT && sin_valid && frame_start) state_nxt = ASSEMBLE;
  end

  always_comb begin
    capture  = 1'b0;
    restart  = 1'b0;
    slip     = 1'b0;
    complete = 1'b0;
    unique case (state)
      HUNT: begin
        capture = sin_valid && frame_start;
        restart = capture;
      end
      ASSEMBLE: begin
        capture  = sin_valid;
        slip     = sin_valid && frame_start && (bit_cnt != '0);
        restart  = slip;
        complete = sin_valid && !slip && (bit_cnt == BW'(CW_W-1));
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (capture) begin
      if (restart) begin
        shreg[0] <= sin;
        bit_cnt  <= BW'(1);
      end else if (complete) begin
        bit_cnt <= '0;
      end else begin
        shreg[bit_cnt] <= sin;
        bit_cnt        <= bit_cnt + 1'b1;
      end
    end
  end

  // The final bit goes straight into the pushed word rather than through shreg.
  always_comb begin
    word = {sin, shreg};
`ifdef CX_ERR_INJECT_EN
    if (inj_en && int'(inj_pos) < CW_W) word[inj_pos] = ~word[inj_pos];
`endif
  end

  assign cx_valid = !fifo_empty;
  assign pop      = cx_valid && cx_ready;
  assign drop     = complete && fifo_full && !pop;

  cw_fifo #(
    .W     (CW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (complete),
    .din   (word),
    .pop   (pop),
    .dout  (cx_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      sync_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overrun  <= drop;
      sync_err <= slip;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cx_deserializer.sv
// Directed self-checking bench for cx_deserializer (injection checks when CX_ERR_INJECT_EN is defined).
module tb_cx_deserializer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        sin_valid;
  logic        frame_start;
  logic [11:0] cx_out;
  logic        cx_valid;
  logic        cx_ready;
  logic        overrun;
  logic        sync_err;
  logic [7:0]  drop_cnt;
`ifdef CX_ERR_INJECT_EN
  logic        inj_en;
  logic [3:0]  inj_pos;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cx_deserializer #(
    .CW_W       (12),
    .FIFO_DEPTH (2),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .cx_out      (cx_out),
    .cx_valid    (cx_valid),
    .cx_ready    (cx_ready),
    .overrun     (overrun),
    .sync_err    (sync_err),
`ifdef CX_ERR_INJECT_EN
    .drop_cnt    (drop_cnt),
    .inj_en      (inj_en),
    .inj_pos     (inj_pos)
`else
    .drop_cnt    (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic b, input logic fs);
    @(negedge clk);
    sin         = b;
    sin_valid   = 1'b1;
    frame_start = fs;
  endtask

  task automatic settle();
    @(negedge clk);
    sin_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w, input logic fs);
    for (int i = 0; i < 12; i++) drive(w[i], fs && (i == 0));
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sin         = 1'b0;
    sin_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] w;
    cx_ready = 1'b1;
`ifdef CX_ERR_INJECT_EN
    inj_en  = 1'b0;
    inj_pos = 4'd0;
`endif
    do_reset();
    check("rst_cx_out",   32'(cx_out),   32'h0);
    check("rst_cx_valid", 32'(cx_valid), 32'h0);
    check("rst_overrun",  32'(overrun),  32'h0);
    check("rst_sync_err", 32'(sync_err), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // Basic word, valid exactly one cycle after the 12th bit
    w = 12'hA5C;
    for (int i = 0; i < 11; i++) drive(w[i], i == 0);
    drive(w[11], 1'b0);
    check("basic_early_valid", 32'(cx_valid), 32'h0);
    settle();
    check("basic_valid", 32'(cx_valid), 32'h1);
    check("basic_data",  32'(cx_out),   32'hA5C);
    @(negedge clk);
    check("basic_valid_drop", 32'(cx_valid), 32'h0);

    // Bits before frame_start are ignored
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    settle();
    check("hunt_no_valid", 32'(cx_valid), 32'h0);
    send_word(12'h3C6, 1'b1);
    settle();
    check("hunt_valid", 32'(cx_valid), 32'h1);
    check("hunt_data",  32'(cx_out),   32'h3C6);
    @(negedge clk);

    // Overrun: third word dropped while FIFO full
    cx_ready = 1'b0;
    send_word(12'h001, 1'b1);
    send_word(12'h002, 1'b0);
    send_word(12'h003, 1'b0);
    settle();
    check("ovr_pulse",    32'(overrun),  32'h1);
    check("ovr_drop_cnt", 32'(drop_cnt), 32'h1);
    check("ovr_head",     32'(cx_out),   32'h001);
    @(negedge clk);
    check("ovr_pulse_end", 32'(overrun), 32'h0);
    check("ovr_hold",      32'(cx_out),  32'h001);
    cx_ready = 1'b1;
    @(negedge clk);
    check("ovr_second",       32'(cx_out),   32'h002);
    check("ovr_second_valid", 32'(cx_valid), 32'h1);
    @(negedge clk);
    check("ovr_empty", 32'(cx_valid), 32'h0);

    // Framing slip after 7 bits
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0);
    w = 12'h5A3;
    drive(w[0], 1'b1);
    check("slip_pre", 32'(sync_err), 32'h0);
    drive(w[1], 1'b0);
    check("slip_pulse",    32'(sync_err), 32'h1);
    check("slip_no_word",  32'(cx_valid), 32'h0);
    drive(w[2], 1'b0);
    check("slip_pulse_end", 32'(sync_err), 32'h0);
    for (int i = 3; i < 12; i++) drive(w[i], 1'b0);
    settle();
    check("slip_valid", 32'(cx_valid), 32'h1);
    check("slip_data",  32'(cx_out),   32'h5A3);
    @(negedge clk);
    check("slip_no_extra", 32'(cx_valid), 32'h0);

    // Completion and pop in the same cycle with FIFO full
    cx_ready = 1'b0;
    send_word(12'h111, 1'b0);
    send_word(12'h222, 1'b0);
    w = 12'h333;
    for (int i = 0; i < 11; i++) drive(w[i], 1'b0);
    drive(w[11], 1'b0);
    cx_ready = 1'b1;
    settle();
    check("pp_no_overrun", 32'(overrun),  32'h0);
    check("pp_drop_cnt",   32'(drop_cnt), 32'h1);
    check("pp_head",       32'(cx_out),   32'h222);
    @(negedge clk);
    check("pp_next", 32'(cx_out), 32'h333);
    @(negedge clk);
    check("pp_empty", 32'(cx_valid), 32'h0);

    // Drop counter saturation
    cx_ready = 1'b0;
    for (int k = 0; k < 255; k++) send_word(12'(12'h100 + k), 1'b0);
    settle();
    check("sat_254", 32'(drop_cnt), 32'd254);
    for (int k = 0; k < 3; k++) send_word(12'hFFF, 1'b0);
    settle();
    check("sat_255",  32'(drop_cnt), 32'd255);
    check("sat_head", 32'(cx_out),   32'h100);

    // Asynchronous reset mid-word with non-empty FIFO
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",    32'(cx_valid), 32'h0);
    check("arst_cx_out",   32'(cx_out),   32'h0);
    check("arst_drop_cnt", 32'(drop_cnt), 32'h0);
    sin_valid   = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    cx_ready = 1'b1;
    send_word(12'hFFF, 1'b0);
    settle();
    check("arst_hunt", 32'(cx_valid), 32'h0);

`ifdef CX_ERR_INJECT_EN
    inj_en  = 1'b1;
    inj_pos = 4'd5;
    send_word(12'h000, 1'b1);
    settle();
    check("inj_pos5", 32'(cx_out), 32'h020);
    @(negedge clk);
    inj_pos = 4'd13;
    send_word(12'h000, 1'b0);
    settle();
    check("inj_pos13_valid", 32'(cx_valid), 32'h1);
    check("inj_pos13",       32'(cx_out),   32'h000);
    @(negedge clk);
    inj_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
